// File: rtl/slt_seq_ctrl_if.sv
// Purpose: request/response and slice-chain bundle for the SLT sequencer.
// Ports (signals):
//   start, is_signed, le, abort, a, b : compare request from the ALU side
//   ready, busy, done, slt            : sequencer status and result
//   slice_a, slice_b, slice_lin       : chunk operands and chain input to the external slice
//   slice_lout                        : chain output returned by the external slice
// The master side is the environment (ALU control plus the external slice);
// the slave side is the sequencer.
interface slt_seq_ctrl_if #(
    parameter int unsigned W = 32,
    parameter int unsigned S = 8
);
    logic         start;
    logic         is_signed;
    logic         le;
    logic         abort;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] slt;
    logic [S-1:0] slice_a;
    logic [S-1:0] slice_b;
    logic         slice_lin;
    logic         slice_lout;

    modport master (
        output start, is_signed, le, abort, a, b, slice_lout,
        input  ready, busy, done, slt, slice_a, slice_b, slice_lin
    );

    modport slave (
        input  start, is_signed, le, abort, a, b, slice_lout,
        output ready, busy, done, slt, slice_a, slice_b, slice_lin
    );
endinterface

// File: rtl/slt_seq_ctrl.sv
// Purpose: multicycle W-bit SLT/SLTU/SLE sequencer that walks an external S-bit
//   compare slice LSB chunk first, one chunk per cycle, registering the less-than
//   chain between chunks and applying the sign correction at the end.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slt_seq_ctrl_if.slave (request, status/result, slice chain)
module slt_seq_ctrl #(
    parameter int unsigned W = 32,
    parameter int unsigned S = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    slt_seq_ctrl_if.slave bus
);
    localparam int unsigned N  = W / S;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [KW-1:0] r_k;
    logic          r_carry;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_sgn;
    logic          r_ready;
    logic          r_busy;
    logic          r_done;
    logic [W-1:0]  r_slt;
    logic [S-1:0]  r_slice_a;
    logic [S-1:0]  r_slice_b;
    logic          r_slice_lin;

    logic [1:0]    w_state_nxt;
    logic [KW-1:0] w_k_nxt;
    logic          w_carry_nxt;
    logic [W-1:0]  w_a_nxt;
    logic [W-1:0]  w_b_nxt;
    logic          w_sgn_nxt;
    logic [W-1:0]  w_slt_nxt;
    logic [S-1:0]  w_slice_a_nxt;
    logic [S-1:0]  w_slice_b_nxt;
    logic          w_slice_lin_nxt;

    // Next-state, datapath and next-output decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_k_nxt         = r_k;
        w_carry_nxt     = r_carry;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_sgn_nxt       = r_sgn;
        w_slt_nxt       = r_slt;
        w_slice_a_nxt   = '0;
        w_slice_b_nxt   = '0;
        w_slice_lin_nxt = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                // DONE accepts a new request exactly like IDLE (back-to-back).
                if (bus.start) begin
                    w_state_nxt = ST_RUN;
                    w_a_nxt     = bus.a;
                    w_b_nxt     = bus.b;
                    w_sgn_nxt   = bus.is_signed;
                    w_carry_nxt = bus.le;
                    w_k_nxt     = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                    w_k_nxt     = '0;
                    w_carry_nxt = 1'b0;
                end else begin
                    w_carry_nxt = bus.slice_lout;
                    if (r_k == KW'(N - 1)) begin
                        w_state_nxt = ST_DONE;
                        w_k_nxt     = '0;
                        // Differing sign bits invert the unsigned verdict.
                        w_slt_nxt   = W'(bus.slice_lout ^ (r_sgn & (r_a[W-1] ^ r_b[W-1])));
                    end else begin
                        w_k_nxt = r_k + KW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Slice drive is registered, so it is computed from the values entering RUN.
        if (w_state_nxt == ST_RUN) begin
            w_slice_a_nxt   = S'(w_a_nxt >> (S * w_k_nxt));
            w_slice_b_nxt   = S'(w_b_nxt >> (S * w_k_nxt));
            w_slice_lin_nxt = w_carry_nxt;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_k         <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sgn       <= 1'b0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_slt       <= '0;
            r_slice_a   <= '0;
            r_slice_b   <= '0;
            r_slice_lin <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_k         <= w_k_nxt;
            r_carry     <= w_carry_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_sgn       <= w_sgn_nxt;
            r_ready     <= (w_state_nxt != ST_RUN);
            r_busy      <= (w_state_nxt == ST_RUN);
            r_done      <= (w_state_nxt == ST_DONE);
            r_slt       <= w_slt_nxt;
            r_slice_a   <= w_slice_a_nxt;
            r_slice_b   <= w_slice_b_nxt;
            r_slice_lin <= w_slice_lin_nxt;
        end
    end

    assign bus.ready     = r_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.slt       = r_slt;
    assign bus.slice_a   = r_slice_a;
    assign bus.slice_b   = r_slice_b;
    assign bus.slice_lin = r_slice_lin;
endmodule

// File: tb/tb_slt_seq_ctrl.sv
// Purpose: self-checking bench for slt_seq_ctrl (W=32, S=8) with a transaction-level
//   reference model, a per-cycle compare process and directed literal checks.
module tb_slt_seq_ctrl;
    localparam int unsigned W = 32;
    localparam int unsigned S = 8;
    localparam int          N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;

    slt_seq_ctrl_if #(.W(W), .S(S)) bus();

    slt_seq_ctrl #(.W(W), .S(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // External slice: chunk-level chain rule.
    always_comb begin
        bus.slice_lout = (bus.slice_a < bus.slice_b) ||
                         ((bus.slice_a == bus.slice_b) && bus.slice_lin);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic ref_lt(input logic [31:0] a, input logic [31:0] b,
                                    input logic sg, input logic le);
        if (a == b) return le;
        if (sg) return $signed(a) < $signed(b);
        return a < b;
    endfunction

    // Chain value after k low chunks: compare of the low k*S bits, seeded by le.
    function automatic logic ref_prefix(input logic [31:0] a, input logic [31:0] b,
                                        input logic le, input int k);
        logic [63:0] mask;
        logic [63:0] alo;
        logic [63:0] blo;
        if (k == 0) return le;
        mask = (64'd1 << (S * k)) - 64'd1;
        alo  = {32'd0, a} & mask;
        blo  = {32'd0, b} & mask;
        return (alo < blo) || ((alo == blo) && le);
    endfunction

    // Reference model: m_left = chunks still to walk (0 when not comparing).
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_slt = '0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic        m_sg = 1'b0;
    logic        m_le = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_slt  <= '0;
            m_a    <= '0;
            m_b    <= '0;
            m_sg   <= 1'b0;
            m_le   <= 1'b0;
        end else if (m_left > 0) begin
            m_done <= 1'b0;
            if (bus.abort) begin
                m_left <= 0;
            end else if (m_left == 1) begin
                m_left <= 0;
                m_done <= 1'b1;
                m_slt  <= {31'd0, ref_lt(m_a, m_b, m_sg, m_le)};
            end else begin
                m_left <= m_left - 1;
            end
        end else begin
            m_done <= 1'b0;
            if (bus.start) begin
                m_a    <= bus.a;
                m_b    <= bus.b;
                m_sg   <= bus.is_signed;
                m_le   <= bus.le;
                m_left <= N;
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        int k;
        logic run;
        k   = N - m_left;
        run = (m_left > 0);
        chk("ready", bus.ready, !run);
        chk("busy", bus.busy, run);
        chk("done", bus.done, m_done);
        chk("slt", bus.slt, m_slt);
        chk("slice_a", bus.slice_a, run ? ((m_a >> (S * k)) & 32'hFF) : 32'd0);
        chk("slice_b", bus.slice_b, run ? ((m_b >> (S * k)) & 32'hFF) : 32'd0);
        chk("slice_lin", bus.slice_lin, run ? ref_prefix(m_a, m_b, m_le, k) : 1'b0);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // One compare with literal latency and result expectations.
    task automatic run_cmp(input logic [31:0] a, input logic [31:0] b, input logic sg,
                           input logic le, input logic [31:0] exp, input string nm);
        int  cyc;
        logic got;
        @(posedge clk); #1;
        bus.a = a; bus.b = b; bus.is_signed = sg; bus.le = le; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (bus.done) got = 1'b1;
        end
        chk({nm, "_lat"}, cyc, 5);
        chk({nm, "_slt"}, bus.slt, exp);
    endtask

    initial begin
        int   nd;
        int   d_idx [4];
        logic [31:0] d_slt [4];
        int   seen;
        int   rdone;

        bus.start = 1'b0; bus.abort = 1'b0; bus.is_signed = 1'b0; bus.le = 1'b0;
        bus.a = '0; bus.b = '0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_ready", bus.ready, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_slt", bus.slt, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_cmp(32'd5, 32'd7, 1'b0, 1'b0, 32'h1, "t1");
        run_cmp(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 32'h1, "t2s");
        run_cmp(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0, "t2u");
        run_cmp(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 32'h0, "t3lt");
        run_cmp(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h1, "t3le");
        run_cmp(32'h0100_0000, 32'h00FF_FFFF, 1'b0, 1'b0, 32'h0, "t4");
        run_cmp(32'h00FF_FFFF, 32'h0100_0000, 1'b0, 1'b0, 32'h1, "t4sw");

        // Start held high: ignored in RUN, re-accepted in the DONE cycle.
        nd = 0;
        for (int i = 0; i < 4; i++) begin d_idx[i] = 0; d_slt[i] = '0; end
        @(posedge clk); #1;
        bus.a = 32'd3; bus.b = 32'd9; bus.is_signed = 1'b0; bus.le = 1'b0; bus.start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (bus.done && nd < 4) begin d_idx[nd] = c; d_slt[nd] = bus.slt; nd++; end
            if (c == 2) bus.a = 32'd100;
        end
        bus.start = 1'b0;
        chk("t5_ndone", nd, 3);
        chk("t5_first", d_idx[0], 6);
        chk("t5_second", d_idx[1], 11);
        chk("t5_slt0", d_slt[0], 32'h1);
        chk("t5_slt1", d_slt[1], 32'h0);
        repeat (8) @(posedge clk);

        // Abort at k=2 after a result of 1: no done, slt retained.
        run_cmp(32'd5, 32'd7, 1'b0, 1'b0, 32'h1, "t6pre");
        @(posedge clk); #1;
        bus.a = 32'd9; bus.b = 32'd2; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        chk("t6_nodone", seen, 0);
        chk("t6_slt", bus.slt, 32'h1);
        chk("t6_ready", bus.ready, 1'b1);

        // Reset in the middle of RUN.
        @(posedge clk); #1;
        bus.a = 32'd1; bus.b = 32'd2; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t6r_busy", bus.busy, 1'b0);
        chk("t6r_ready", bus.ready, 1'b1);
        chk("t6r_slt", bus.slt, 32'h0);
        chk("t6r_slice_a", bus.slice_a, 8'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Randomized traffic checked by the model.
        rdone = 0;
        for (int i = 0; i < 600; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            @(posedge clk); #1;
            ra = $urandom;
            case ($urandom_range(3))
                0: rb = $urandom;
                1: rb = ra;
                2: rb = ra ^ (32'd1 << $urandom_range(31));
                default: begin ra[31] = $urandom_range(1); rb = ra ^ 32'h8000_0000; end
            endcase
            bus.a = ra; bus.b = rb;
            bus.is_signed = 1'($urandom_range(1));
            bus.le = 1'($urandom_range(1));
            bus.start = ($urandom_range(2) == 0);
            bus.abort = ($urandom_range(15) == 0);
            @(negedge clk);
            if (bus.done) rdone++;
        end
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("rand_dones", (rdone > 10), 1'b1);
        repeat (8) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
